// File: rtl/stream_mux_rr_if.sv
// ---------------------------------------------------------------------------
// stream_mux_rr_if
//
// Bundles the stream-side signals of the stream_mux_rr sample multiplexer:
// the N parallel input channels (flattened data, per-channel valid/ready) and
// the single registered output stream (data, channel tag, valid/ready).
//
// Parameters
//   NUM_CH  number of input channels (>= 2)
//   DATA_W  sample width in bits
//
// Signals
//   in_data    NUM_CH*DATA_W  channel i occupies bits [i*DATA_W +: DATA_W]
//   in_valid   NUM_CH         per-channel sample valid
//   in_ready   NUM_CH         per-channel accept from the mux, one-hot or zero
//   out_data   DATA_W         registered selected sample
//   out_ch     CH_W           channel that produced out_data
//   out_valid  1              out_data/out_ch valid
//   out_ready  1              downstream accept
//
// Modports
//   master  producer/consumer side (drives inputs, observes outputs)
//   slave   the multiplexer itself
// ---------------------------------------------------------------------------
interface stream_mux_rr_if #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 16
);

  localparam int CH_W = $clog2(NUM_CH);

  logic [NUM_CH*DATA_W-1:0] in_data;
  logic [NUM_CH-1:0]        in_valid;
  logic [NUM_CH-1:0]        in_ready;
  logic [DATA_W-1:0]        out_data;
  logic [CH_W-1:0]          out_ch;
  logic                     out_valid;
  logic                     out_ready;

  modport master (
    output in_data,
    output in_valid,
    output out_ready,
    input  in_ready,
    input  out_data,
    input  out_ch,
    input  out_valid
  );

  modport slave (
    input  in_data,
    input  in_valid,
    input  out_ready,
    output in_ready,
    output out_data,
    output out_ch,
    output out_valid
  );

endinterface

// File: rtl/stream_mux_rr.sv
// ---------------------------------------------------------------------------
// stream_mux_rr
//
// Registered N-to-1 sample multiplexer for DSP streams. Every cycle one input
// channel may be granted; its sample is captured into the output register
// together with the channel index. Two selection modes:
//   mode = 0  static: the channel named by sel is granted when it is valid
//   mode = 1  round-robin: the first valid channel at or after the rotating
//             pointer is granted, giving every channel a fair share
//
// Ports
//   clk    rising-edge clock
//   rst    synchronous, active-high reset
//   mode   selection mode (0 static, 1 round-robin)
//   sel    channel index used in static mode
//   bus    stream_mux_rr_if.slave: input channels and registered output
//
// The output register refills in the same cycle it drains, so one sample per
// cycle is sustained while out_ready stays high.
// ---------------------------------------------------------------------------
module stream_mux_rr #(
  parameter  int NUM_CH = 4,
  parameter  int DATA_W = 16,
  localparam int CH_W   = $clog2(NUM_CH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            mode,
  input  logic [CH_W-1:0] sel,
  stream_mux_rr_if.slave  bus
);

  // Number of index codes representable in CH_W bits; lets a channel index be
  // used to look up a valid bit even when it is beyond the last channel.
  localparam int NUM_SLOTS = 1 << CH_W;

  // Channel count and last channel as CH_W-sized constants so that every
  // index comparison stays unsigned at the index width.
  localparam logic [CH_W:0]   NUM_CH_V = (CH_W + 1)'(NUM_CH);
  localparam logic [CH_W-1:0] LAST_CH  = CH_W'(NUM_CH - 1);

  // Output register and round-robin pointer
  logic [DATA_W-1:0] data_q;
  logic [CH_W-1:0]   ch_q;
  logic              valid_q;
  logic [CH_W-1:0]   ptr;

  // Grant datapath
  logic                 load_en;
  logic [NUM_SLOTS-1:0] valid_pad;
  logic                 static_valid;
  logic                 rr_valid;
  logic [CH_W-1:0]      rr_grant;
  logic [CH_W:0]        idx;
  logic                 grant_valid;
  logic [CH_W-1:0]      grant;
  logic [DATA_W-1:0]    grant_data;
  logic                 transfer;
  logic [CH_W-1:0]      ptr_next;
  logic [NUM_CH-1:0]    ready;

  // The output register can take a new sample when it is empty or when its
  // current sample leaves this cycle.
  assign load_en = !valid_q || bus.out_ready;

  // Zero-extended valid vector: index codes past the last channel read as
  // "not valid", so an out-of-range sel never grants.
  assign valid_pad = NUM_SLOTS'(bus.in_valid);

  assign static_valid = ({1'b0, sel} < NUM_CH_V) && valid_pad[sel];

  // Round-robin search. The scan runs from the farthest offset back to the
  // pointer itself so that the last hit written is the one closest to ptr,
  // i.e. the first valid channel in the order ptr, ptr+1, ..., ptr-1.
  always_comb begin
    rr_valid = 1'b0;
    rr_grant = '0;
    idx      = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      idx = {1'b0, ptr} + (CH_W + 1)'(k);
      if (idx >= NUM_CH_V) begin
        idx = idx - NUM_CH_V;
      end
      if (valid_pad[idx[CH_W-1:0]]) begin
        rr_valid = 1'b1;
        rr_grant = idx[CH_W-1:0];
      end
    end
  end

  // Mode selects between the two grant sources with no pipelining, so a
  // change of mode or sel affects this very cycle's grant.
  assign grant_valid = mode ? rr_valid : static_valid;
  assign grant       = mode ? rr_grant : sel;

  // No transfer may happen in a reset cycle, so reset also gates the grant.
  assign transfer = !rst && load_en && grant_valid;

  // Sample of the granted channel. Written as a compare-per-channel loop so
  // that no slice is ever taken beyond the end of in_data.
  always_comb begin
    grant_data = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (grant == CH_W'(i)) begin
        grant_data = bus.in_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Per-channel ready: only the granted channel sees ready, and only when the
  // output register can take its sample.
  always_comb begin
    ready = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      ready[i] = transfer && (grant == CH_W'(i));
    end
  end

  assign bus.in_ready = ready;

  // Round-robin pointer moves just past the channel that was served.
  assign ptr_next = (grant == LAST_CH) ? '0 : grant + 1'b1;

  // Output register and pointer. A stalled output (load_en low) freezes
  // everything; an empty grant with load_en high just drops out_valid and
  // leaves the last sample and tag visible.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= '0;
      ch_q    <= '0;
      valid_q <= 1'b0;
      ptr     <= '0;
    end else if (load_en) begin
      if (grant_valid) begin
        data_q  <= grant_data;
        ch_q    <= grant;
        valid_q <= 1'b1;
        if (mode) begin
          ptr <= ptr_next;
        end
      end else begin
        valid_q <= 1'b0;
      end
    end
  end

  assign bus.out_data  = data_q;
  assign bus.out_ch    = ch_q;
  assign bus.out_valid = valid_q;

endmodule

// File: tb/tb_stream_mux_rr.sv
// ---------------------------------------------------------------------------
// tb_stream_mux_rr
//
// Directed bench for stream_mux_rr. Two instances share clk/rst: a 4-channel
// one carrying most of the sequence and a 3-channel one used where an index
// beyond the last channel is needed. Inputs change 1 ns after a rising edge;
// combinational ready is checked 1 ns later and registered outputs 1 ns after
// the following edge.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_stream_mux_rr;

  logic       clk = 1'b0;
  logic       rst;
  logic       mode4;
  logic [1:0] sel4;
  logic       mode3;
  logic [1:0] sel3;

  int checks = 0;
  int errors = 0;

  stream_mux_rr_if #(.NUM_CH(4), .DATA_W(16)) bus4 ();
  stream_mux_rr_if #(.NUM_CH(3), .DATA_W(16)) bus3 ();

  stream_mux_rr #(.NUM_CH(4), .DATA_W(16)) u_dut4 (
    .clk  (clk),
    .rst  (rst),
    .mode (mode4),
    .sel  (sel4),
    .bus  (bus4.slave)
  );

  stream_mux_rr #(.NUM_CH(3), .DATA_W(16)) u_dut3 (
    .clk  (clk),
    .rst  (rst),
    .mode (mode3),
    .sel  (sel3),
    .bus  (bus3.slave)
  );

  // Free-running 100 MHz clock
  always #5 clk = ~clk;

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive the 4-channel instance's control and handshake inputs
  task automatic apply_stimulus(input logic m, input logic [1:0] s,
                                input logic [3:0] v, input logic r);
    mode4          = m;
    sel4           = s;
    bus4.in_valid  = v;
    bus4.out_ready = r;
  endtask

  // Channel i of the 4-channel instance carries 16'hA000 + i
  task automatic load_tag_data();
    for (int i = 0; i < 4; i++) begin
      bus4.in_data[i*16 +: 16] = 16'hA000 + 16'(i);
    end
  endtask

  task automatic check_output(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  initial begin
    logic [1:0] sparse_seq [4];
    logic [1:0] fair_seq   [6];
    sparse_seq = '{2'd1, 2'd3, 2'd1, 2'd3};
    fair_seq   = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

    // Reset held two cycles with every channel valid
    rst = 1'b1;
    bus4.in_data = '0;
    apply_stimulus(1'b0, 2'd0, 4'b1111, 1'b1);
    mode3          = 1'b0;
    sel3           = 2'd0;
    bus3.in_data   = '0;
    bus3.in_valid  = 3'b000;
    bus3.out_ready = 1'b1;
    #1;
    check_output("rst_ready_0", 64'(bus4.in_ready), 64'h0);
    tick();
    check_output("rst_ready_1", 64'(bus4.in_ready), 64'h0);
    tick();
    check_output("rst_ready_2", 64'(bus4.in_ready), 64'h0);
    check_output("rst_out_valid", 64'(bus4.out_valid), 64'h0);
    check_output("rst_out_data", 64'(bus4.out_data), 64'h0);
    check_output("rst_out_ch", 64'(bus4.out_ch), 64'h0);

    // Static select of channel 2
    rst = 1'b0;
    bus4.in_data[32 +: 16] = 16'h1234;
    apply_stimulus(1'b0, 2'd2, 4'b0100, 1'b1);
    #1;
    check_output("static_ready", 64'(bus4.in_ready), 64'h4);
    tick();
    check_output("static_valid", 64'(bus4.out_valid), 64'h1);
    check_output("static_data", 64'(bus4.out_data), 64'h1234);
    check_output("static_ch", 64'(bus4.out_ch), 64'h2);

    // Selected channel idle while the others are valid: no grant, output drops
    apply_stimulus(1'b0, 2'd2, 4'b1011, 1'b1);
    #1;
    check_output("static_idle_ready", 64'(bus4.in_ready), 64'h0);
    tick();
    check_output("static_idle_valid", 64'(bus4.out_valid), 64'h0);
    check_output("static_idle_data_hold", 64'(bus4.out_data), 64'h1234);
    check_output("static_idle_ch_hold", 64'(bus4.out_ch), 64'h2);

    // Round-robin with all channels valid: 0,1,2,3,0,1 back to back
    load_tag_data();
    apply_stimulus(1'b1, 2'd0, 4'b1111, 1'b1);
    #1;
    check_output("fair_first_ready", 64'(bus4.in_ready), 64'h1);
    for (int k = 0; k < 6; k++) begin
      tick();
      check_output("fair_ch", 64'(bus4.out_ch), 64'(fair_seq[k]));
      check_output("fair_data", 64'(bus4.out_data), 64'h0000A000 + 64'(fair_seq[k]));
      check_output("fair_valid", 64'(bus4.out_valid), 64'h1);
    end

    // Sparse round-robin from a fresh pointer
    rst = 1'b1;
    apply_stimulus(1'b1, 2'd0, 4'b0000, 1'b1);
    tick();
    rst = 1'b0;
    check_output("sparse_rst_valid", 64'(bus4.out_valid), 64'h0);
    for (int k = 0; k < 4; k++) begin
      apply_stimulus(1'b1, 2'd0, 4'b1010, 1'b1);
      tick();
      check_output("sparse_ch", 64'(bus4.out_ch), 64'(sparse_seq[k]));
      check_output("sparse_data", 64'(bus4.out_data), 64'h0000A000 + 64'(sparse_seq[k]));
    end
    apply_stimulus(1'b1, 2'd0, 4'b0001, 1'b1);
    #1;
    check_output("sparse_wrap_ready", 64'(bus4.in_ready), 64'h1);
    tick();
    check_output("sparse_wrap_ch", 64'(bus4.out_ch), 64'h0);
    check_output("sparse_wrap_data", 64'(bus4.out_data), 64'hA000);

    // Backpressure: load channel 1, then stall three cycles
    apply_stimulus(1'b1, 2'd0, 4'b1111, 1'b1);
    #1;
    check_output("bp_first_ready", 64'(bus4.in_ready), 64'h2);
    tick();
    check_output("bp_load_ch", 64'(bus4.out_ch), 64'h1);
    bus4.out_ready = 1'b0;
    bus4.in_data[16 +: 16] = 16'h5555;
    #1;
    check_output("bp_stall_ready", 64'(bus4.in_ready), 64'h0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check_output("bp_hold_ch", 64'(bus4.out_ch), 64'h1);
      check_output("bp_hold_data", 64'(bus4.out_data), 64'hA001);
      check_output("bp_hold_valid", 64'(bus4.out_valid), 64'h1);
      check_output("bp_hold_ready", 64'(bus4.in_ready), 64'h0);
    end
    bus4.in_data[16 +: 16] = 16'hA001;
    bus4.out_ready = 1'b1;
    #1;
    check_output("bp_resume_ready", 64'(bus4.in_ready), 64'h4);
    tick();
    check_output("bp_resume_ch", 64'(bus4.out_ch), 64'h2);
    check_output("bp_resume_data", 64'(bus4.out_data), 64'hA002);

    // 4-channel instance idles while the 3-channel one is exercised
    apply_stimulus(1'b1, 2'd0, 4'b0000, 1'b1);
    tick();
    check_output("idle4_valid", 64'(bus4.out_valid), 64'h0);

    // 3 channels: valid static select, then sel=3 which is past the last one
    bus3.in_data  = {16'hB002, 16'hB001, 16'hB000};
    bus3.in_valid = 3'b111;
    mode3 = 1'b0;
    sel3  = 2'd1;
    #1;
    check_output("n3_static_ready", 64'(bus3.in_ready), 64'h2);
    tick();
    check_output("n3_static_valid", 64'(bus3.out_valid), 64'h1);
    check_output("n3_static_ch", 64'(bus3.out_ch), 64'h1);
    check_output("n3_static_data", 64'(bus3.out_data), 64'hB001);
    sel3 = 2'd3;
    #1;
    check_output("n3_badsel_ready", 64'(bus3.in_ready), 64'h0);
    tick();
    check_output("n3_badsel_valid", 64'(bus3.out_valid), 64'h0);
    check_output("n3_badsel_ch_hold", 64'(bus3.out_ch), 64'h1);

    // Load both instances so a sample is in flight when reset arrives.
    // The 4-channel pointer sits at 3, so it serves 3 then 0 (pointer -> 1).
    sel3 = 2'd2;
    apply_stimulus(1'b1, 2'd0, 4'b1111, 1'b1);
    tick();
    check_output("pre_rst_ch4_a", 64'(bus4.out_ch), 64'h3);
    tick();
    check_output("pre_rst_ch4_b", 64'(bus4.out_ch), 64'h0);
    check_output("pre_rst_valid3", 64'(bus3.out_valid), 64'h1);
    check_output("pre_rst_ch3", 64'(bus3.out_ch), 64'h2);

    // Mid-stream reset: no transfer in the reset cycle, in-flight data dropped
    rst = 1'b1;
    #1;
    check_output("mid_rst_ready4", 64'(bus4.in_ready), 64'h0);
    check_output("mid_rst_ready3", 64'(bus3.in_ready), 64'h0);
    tick();
    check_output("mid_rst_valid4", 64'(bus4.out_valid), 64'h0);
    check_output("mid_rst_valid3", 64'(bus3.out_valid), 64'h0);
    check_output("mid_rst_ch4", 64'(bus4.out_ch), 64'h0);
    check_output("mid_rst_data4", 64'(bus4.out_data), 64'h0);

    // After release, round-robin restarts from channel 0 on both instances
    rst   = 1'b0;
    mode3 = 1'b1;
    #1;
    check_output("post_rst_ready4", 64'(bus4.in_ready), 64'h1);
    check_output("post_rst_ready3", 64'(bus3.in_ready), 64'h1);
    tick();
    check_output("post_rst_ch4", 64'(bus4.out_ch), 64'h0);
    check_output("post_rst_data4", 64'(bus4.out_data), 64'hA000);
    check_output("post_rst_ch3", 64'(bus3.out_ch), 64'h0);
    check_output("post_rst_data3", 64'(bus3.out_data), 64'hB000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
